// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared encodings and constants for the multiply/divide unit
package muldiv_unit_pkg;

    localparam int MD_DEFAULT_BITS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Quotient reported for a zero divisor; every bit is set, so the top
    // replicates bit 0 to whatever operand width it is built with.
    localparam logic [MD_DEFAULT_BITS-1:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring-division step
module div_iter_step #(
    parameter int DATA_BITS = 32
) (
    input  logic [DATA_BITS-1:0] rem_i,
    input  logic [DATA_BITS-1:0] quo_i,
    input  logic [DATA_BITS-1:0] divisor_i,
    output logic [DATA_BITS-1:0] rem_o,
    output logic [DATA_BITS-1:0] quo_o
);

    logic [DATA_BITS:0] shifted;
    logic [DATA_BITS:0] trial;

    // Shift the next dividend bit into the remainder, trial-subtract, keep on no borrow.
    always_comb begin
        shifted = {rem_i, quo_i[DATA_BITS-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[DATA_BITS]) begin
            rem_o = shifted[DATA_BITS-1:0];
            quo_o = {quo_i[DATA_BITS-2:0], 1'b0};
        end else begin
            rem_o = trial[DATA_BITS-1:0];
            quo_o = {quo_i[DATA_BITS-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multicycle multiply/divide unit with architectural HI/LO
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_BITS = MD_DEFAULT_BITS,
    parameter int CNT_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0] b,
    input  logic                 mthi,
    input  logic                 mtlo,
    input  logic                 cancel,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] lo,
    output logic [DATA_BITS-1:0] hi
);

    md_state_e            state_q, state_d;
    md_op_e               op_q, op_d;
    logic [DATA_BITS-1:0] a_q, a_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic [DATA_BITS-1:0] rem_q, rem_d;
    logic [DATA_BITS-1:0] quo_q, quo_d;
    logic [DATA_BITS-1:0] dvs_q, dvs_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [DATA_BITS-1:0] hi_q, hi_d;
    logic [DATA_BITS-1:0] lo_q, lo_d;
    logic                 done_q, done_d;

    logic [DATA_BITS-1:0]   rem_nx, quo_nx;
    logic [2*DATA_BITS-1:0] ext_a, ext_b, prod;
    logic [DATA_BITS-1:0]   q_fix, r_fix;
    logic                   mul_signed, a_in_neg, b_in_neg;

    div_iter_step #(.DATA_BITS(DATA_BITS)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_nx),
        .quo_o     (quo_nx)
    );

    // Product and sign-fixup datapath; the low 2W bits of a 2W-wide product
    // of extended operands are correct for both signed and unsigned forms.
    always_comb begin
        mul_signed = (op_q == MD_MULT);
        ext_a      = {{DATA_BITS{mul_signed & a_q[DATA_BITS-1]}}, a_q};
        ext_b      = {{DATA_BITS{mul_signed & b_q[DATA_BITS-1]}}, b_q};
        prod       = ext_a * ext_b;
        q_fix      = quo_q;
        r_fix      = rem_q;
        if (op_q == MD_DIV) begin
            if (a_q[DATA_BITS-1] ^ b_q[DATA_BITS-1]) q_fix = -quo_q;
            if (a_q[DATA_BITS-1])                    r_fix = -rem_q;
        end
        a_in_neg = (op == MD_DIV) && a[DATA_BITS-1];
        b_in_neg = (op == MD_DIV) && b[DATA_BITS-1];
    end

    // Next-state and register updates; cancel overrides every other input.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_d = md_op_e'(op);
                        a_d  = a;
                        b_d  = b;
                        if (op[1]) begin
                            state_d = ST_DIV;
                            rem_d   = '0;
                            cnt_d   = '0;
                            quo_d   = a_in_neg ? -a : a;
                            dvs_d   = b_in_neg ? -b : b;
                        end else begin
                            state_d = ST_MUL;
                        end
                    end else begin
                        if (mthi) hi_d = a;
                        if (mtlo) lo_d = a;
                    end
                end
                ST_MUL: begin
                    hi_d    = prod[2*DATA_BITS-1:DATA_BITS];
                    lo_d    = prod[DATA_BITS-1:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_DIV: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + CNT_BITS'(1);
                    if (cnt_q == CNT_BITS'(DATA_BITS - 1)) state_d = ST_FIX;
                end
                ST_FIX: begin
                    if (b_q == '0) begin
                        lo_d = {DATA_BITS{DIV_ZERO_LO[0]}};
                        hi_d = a_q;
                    end else begin
                        lo_d = q_fix;
                        hi_d = r_fix;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multicycle integer multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside the ALU and supplies the lo/hi operands that the writeback mux selects for MFLO/MFHI. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It raises busy so the hazard unit can stall MFHI/MFLO and any further mult/div until the result is committed.

Parameters:
DATA_BITS, 32, operand and HI/LO width; divide iteration count equals DATA_BITS
CNT_BITS, 6, iteration counter width; must satisfy 2^CNT_BITS > DATA_BITS

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch operation in op; sampled only when busy=0
op  input  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
a  input  DATA_BITS  rs operand (multiplicand or dividend)
b  input  DATA_BITS  rt operand (multiplier or divisor)
mthi  input  1  write a to HI
mtlo  input  1  write a to LO
cancel  input  1  exception flush; aborts any in-flight operation
busy  output  1  operation in flight; HI/LO not yet valid
done  output  1  one-cycle pulse in the first cycle new mult/div HI/LO is visible
lo  output  DATA_BITS  LO register
hi  output  DATA_BITS  HI register

Behaviour:
- Reset (rst_n=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal regs=0.
- States: IDLE, MUL, DIV, FIX. busy=1 in every state except IDLE. done is a registered output, high only in the cycle after a FIX->IDLE or MUL->IDLE transition.
- IDLE, start=1: latch a, b and op.
  - op[1]=0 goes to MUL.
  - op[1]=1 goes to DIV: load magnitudes (|a|, |b| for DIV; raw values for DIVU), remainder=0, counter=0.
- MUL: one cycle. The 2*DATA_BITS product is computed signed or unsigned. hi=product[63:32], lo=product[31:0] are written at the exit edge, then IDLE. Start to done is 2 edges; busy is high for 1 cycle.
- DIV: restoring division, one quotient bit per cycle, DATA_BITS cycles. Go to FIX when counter=DATA_BITS-1.
- FIX: apply signs (DIV only). Quotient is negated if a and b signs differ. Remainder takes the sign of the dividend. Write lo=quotient and hi=remainder, then IDLE. Divide busy time is DATA_BITS+1 cycles (33).
- Divide by zero: decided result, same latency. lo=all-ones, hi=a (unmodified dividend), for both DIV and DIVU.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- mthi/mtlo: honoured only in IDLE with start=0. HI or LO is written at the next edge. Both asserted writes both. busy and done are unaffected.
- mthi/mtlo while busy: ignored (the hazard unit stalls these).
- Simultaneous start and mthi/mtlo in IDLE: start wins and the mt write is dropped.
- start while busy: ignored; no queueing.
- cancel=1: forces IDLE at the next edge from any state. HI/LO are unchanged, done=0, and start in the same cycle is ignored. cancel has priority over all other inputs.
- hi and lo are direct register outputs with no bypass. Consumers read committed values only.

Decomposition:
- Shared package holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
  - state encodings
  - DIV_ZERO_LO constant (all-ones)
- Natural sub-module: div_iter_step, a combinational single restoring step (shift, trial subtract, quotient bit). It is instantiated once inside muldiv_unit. The multiplier stays inline.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> done after 2 edges; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy for 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO a=0xDEADBEEF while idle -> lo=0xDEADBEEF next cycle and hi unchanged. MTHI asserted during a DIV -> hi unchanged after done. start with mtlo in the same idle cycle -> MUL result only.
- cancel at cycle 10 of a DIV -> IDLE next edge, busy=0, no done pulse, hi/lo equal to their pre-DIV values. start during busy -> no effect on the result.
- rst_n dropped mid-DIV, asynchronously, between edges -> busy, hi, lo and done go to 0 immediately. After release, a MULTU 5*6 gives lo=30, hi=0.
